// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Decides, every cycle, whether the front end advances, stalls or is flushed,
// and where the ID-stage operands should be sourced from (bypass network).
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   id_rn, id_rm          : ID-stage source register numbers
//   id_use_rn, id_use_rm  : ID instruction actually reads that source
//   ex_rd/mem_rd/wb_rd    : destination register of the EX/MEM/WB instruction
//   ex_rf_en/...          : that instruction writes the register file
//   ex_load               : EX instruction is a data-memory load
//   branch_taken          : branch resolved taken in EX
//   dmem_busy             : data memory needs another wait cycle
//   pc_ld, ifid_ld        : PC / IF-ID load enables
//   ifid_flush            : clear the IF-ID register
//   nop_sel               : 1 = inject zeroed control into ID/EX
//   fwd_a, fwd_b          : operand source 00 regfile, 01 EX, 10 MEM, 11 WB
//   state                 : 00 RUN, 01 MEM_WAIT, 10 FLUSH
//
// Optional build macro HAZARD_CTRL_STATS_EN adds saturating 16-bit counters
//   stall_cnt (load-use stall cycles) and flush_cnt (entries into FLUSH).
//
// Only the FSM state and branch_pend are registered; every other output is a
// combinational function of those and the current inputs.

module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] id_rn,
  input  logic [3:0] id_rm,
  input  logic       id_use_rn,
  input  logic       id_use_rm,
  input  logic [3:0] ex_rd,
  input  logic [3:0] mem_rd,
  input  logic [3:0] wb_rd,
  input  logic       ex_rf_en,
  input  logic       mem_rf_en,
  input  logic       wb_rf_en,
  input  logic       ex_load,
  input  logic       branch_taken,
  input  logic       dmem_busy,
  output logic       pc_ld,
  output logic       ifid_ld,
  output logic       ifid_flush,
  output logic       nop_sel,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] state
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_FLUSH    = 2'b10
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   branch_pend;
  logic   nxt_pend;
  logic   load_use;
  logic   do_stall;

  // Register 15 (PC) is never a bypass candidate; an unread operand also
  // reports the register file so downstream muxes stay quiet.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       use_src,
    input logic [3:0] e_rd,
    input logic [3:0] m_rd,
    input logic [3:0] w_rd,
    input logic       e_ok,
    input logic       m_ok,
    input logic       w_ok
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && src != 4'd15) begin
      if (e_ok && e_rd == src)      sel = 2'b01;
      else if (m_ok && m_rd == src) sel = 2'b10;
      else if (w_ok && w_rd == src) sel = 2'b11;
    end
    return sel;
  endfunction

  // A load in EX cannot forward its data yet, so it is skipped here and the
  // load-use stall covers the dependent instruction instead.
  always_comb begin
    if (reset) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end else begin
      fwd_a = fwd_sel(id_rn, id_use_rn, ex_rd, mem_rd, wb_rd,
                      ex_rf_en & ~ex_load, mem_rf_en, wb_rf_en);
      fwd_b = fwd_sel(id_rm, id_use_rm, ex_rd, mem_rd, wb_rd,
                      ex_rf_en & ~ex_load, mem_rf_en, wb_rf_en);
    end
  end

  assign load_use = ex_load & ex_rf_en & (ex_rd != 4'd15) &
                    ((id_use_rn & (ex_rd == id_rn)) |
                     (id_use_rm & (ex_rd == id_rm)));

  // Priority: reset > dmem_busy > taken/pending branch > load-use.
  always_comb begin
    pc_ld      = 1'b1;
    ifid_ld    = 1'b1;
    ifid_flush = 1'b0;
    nop_sel    = 1'b0;
    do_stall   = 1'b0;
    nxt_state  = S_RUN;
    nxt_pend   = branch_pend;
    if (reset) begin
      pc_ld    = 1'b0;
      ifid_ld  = 1'b0;
      nop_sel  = 1'b1;
      nxt_pend = 1'b0;
    end else if (dmem_busy) begin
      // Whole pipe frozen; a branch resolving during the wait is remembered
      // so it can be honoured once memory releases.
      pc_ld     = 1'b0;
      ifid_ld   = 1'b0;
      nxt_state = S_MEM_WAIT;
      if (cur_state == S_MEM_WAIT && branch_taken) nxt_pend = 1'b1;
    end else if (cur_state == S_FLUSH) begin
      ifid_flush = 1'b1;
      nop_sel    = 1'b1;
    end else if (branch_taken || (cur_state == S_MEM_WAIT && branch_pend)) begin
      ifid_flush = 1'b1;
      nop_sel    = 1'b1;
      nxt_state  = S_FLUSH;
      nxt_pend   = 1'b0;
    end else if (load_use) begin
      pc_ld    = 1'b0;
      ifid_ld  = 1'b0;
      nop_sel  = 1'b1;
      do_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cur_state   <= nxt_state;
    branch_pend <= nxt_pend;
  end

  assign state = cur_state;

`ifdef HAZARD_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (do_stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (nxt_state == S_FLUSH && cur_state != S_FLUSH && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
